// File: rtl/cmplx_mult_arbiter_if.sv
// cmplx_mult_arbiter_if: client request/response bus plus multiplier op/res handshake
interface cmplx_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 32,
    parameter int RES_W   = 34
);
    logic [NUM_REQ-1:0]      req_val;
    logic [NUM_REQ*OP_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_val;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [RES_W-1:0]        rsp_data;
    logic                    rsp_err;
    logic                    mult_sw_rst;
    logic                    mult_op_val;
    logic                    mult_op_ready;
    logic [OP_W-1:0]         mult_op;
    logic                    mult_res_val;
    logic                    mult_res_ready;
    logic [RES_W-1:0]        mult_res;

    modport master (
        input  req_val, req_data, rsp_ready, mult_op_ready, mult_res_val, mult_res,
        output req_ready, rsp_val, rsp_data, rsp_err, mult_sw_rst, mult_op_val, mult_op, mult_res_ready
    );

    modport slave (
        output req_val, req_data, rsp_ready, mult_op_ready, mult_res_val, mult_res,
        input  req_ready, rsp_val, rsp_data, rsp_err, mult_sw_rst, mult_op_val, mult_op, mult_res_ready
    );
endinterface

// File: rtl/cmplx_mult_arbiter.sv
// cmplx_mult_arbiter: round-robin sharing of one non-pipelined complex multiplier with a result watchdog
module cmplx_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 32,
    parameter int RES_W   = 34,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sw_rst,
    cmplx_mult_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RETURN} state_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d, sel_op;
    logic [RES_W-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [GW-1:0]   gnt_q, gnt_d, last_gnt_q, last_gnt_d, sel;
    logic            found, expire;
    int              idx;

    // watchdog fires only when no result arrives in the last allowed cycle
    assign expire = (TIMEOUT != 0) && (state_q == WAIT_RES) && !bus.mult_res_val
                    && (wd_cnt_q == WW'(TIMEOUT - 1));

    // round-robin pick: first valid requester after the last one served
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        sel_op = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt_q) + k) % NUM_REQ;
            if (!found && bus.req_val[idx]) begin
                found  = 1'b1;
                sel    = GW'(idx);
                sel_op = bus.req_data[idx*OP_W +: OP_W];
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            op_q       <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            wd_cnt_q   <= '0;
            gnt_q      <= '0;
            last_gnt_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            res_q      <= res_d;
            err_q      <= err_d;
            wd_cnt_q   <= wd_cnt_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // next state; software reset overrides every transition and drops any result in flight
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        err_d      = err_q;
        wd_cnt_d   = wd_cnt_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        if (sw_rst) begin
            state_d    = IDLE;
            op_d       = '0;
            res_d      = '0;
            err_d      = 1'b0;
            wd_cnt_d   = '0;
            gnt_d      = '0;
            last_gnt_d = GW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    op_d    = sel_op;
                    gnt_d   = sel;
                    state_d = ISSUE;
                end
                ISSUE: if (bus.mult_op_ready) begin
                    wd_cnt_d = '0;
                    state_d  = WAIT_RES;
                end
                WAIT_RES: if (bus.mult_res_val) begin
                    res_d   = bus.mult_res;
                    err_d   = 1'b0;
                    state_d = RETURN;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (expire) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RETURN;
                    end
                end
                default: if (bus.rsp_ready[gnt_q]) begin
                    last_gnt_d = gnt_q;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    // outputs decoded from state; accept is masked while any reset is active
    always_comb begin
        bus.req_ready      = (state_q == IDLE && found && rstn && !sw_rst) ? (NUM_REQ'(1) << sel) : '0;
        bus.rsp_val        = (state_q == RETURN) ? (NUM_REQ'(1) << gnt_q) : '0;
        bus.rsp_data       = (state_q == RETURN) ? res_q : '0;
        bus.rsp_err        = (state_q == RETURN) && err_q;
        bus.mult_sw_rst    = sw_rst || expire;
        bus.mult_op_val    = (state_q == ISSUE);
        bus.mult_op        = op_q;
        bus.mult_res_ready = (state_q == WAIT_RES);
    end
endmodule
